// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and BCD decode table
package seg7_pkg;

   // Active-low segment patterns {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Maps one BCD code to its active-low segment pattern; codes 10..15 show a dash
   function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
      logic [6:0] pattern;
      case (bcd)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = SEG_DASH;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low seven-segment decoder
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure table lookup on the selected digit
   always_comb begin
      seg = seg7_decode(bcd);
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - 4-digit multiplexed common-anode display scanner
module seven_seg_scanner
   import seg7_pkg::*;
#(
   parameter int DIV_WIDTH    = 18,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_en,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [DIV_WIDTH-1:0] CNT_ONE   = 1;
   localparam logic [DIV_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [DIV_WIDTH-1:0] BLANK_LIM = BLANK_CYCLES[DIV_WIDTH-1:0];

   logic [DIV_WIDTH-1:0] cnt;
   logic [1:0]           sel;
   logic [3:0]           digit_mux;
   logic [6:0]           seg_dec;
   logic [3:0]           lz_mask;
   logic                 dp_mux;

   // Prescaler and digit selector; sel steps on the prescaler wrap cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sel <= 2'd0;
      end else begin
         cnt <= cnt + CNT_ONE;
         if (cnt == CNT_MAX) begin
            sel <= sel + 2'd1;
         end
      end
   end

   // Select the active digit and its decimal-point request
   always_comb begin
      digit_mux = digits[3:0];
      dp_mux    = dp_en[sel];
      case (sel)
         2'd0:    digit_mux = digits[3:0];
         2'd1:    digit_mux = digits[7:4];
         2'd2:    digit_mux = digits[11:8];
         default: digit_mux = digits[15:12];
      endcase
   end

   // Leading-zero chain: a digit blanks only if it and every digit left of it are zero
   always_comb begin
      lz_mask    = 4'b0000;
      lz_mask[3] = blank_lz && (digits[15:12] == 4'd0);
      lz_mask[2] = lz_mask[3] && (digits[11:8] == 4'd0);
      lz_mask[1] = lz_mask[2] && (digits[7:4] == 4'd0);
      lz_mask[0] = 1'b0;
   end

   bcd_to_seg7 u_dec (
      .bcd (digit_mux),
      .seg (seg_dec)
   );

   // Registered outputs with anti-ghosting blank window at the start of each slot
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else if (cnt < BLANK_LIM) begin
         an  <= 4'b1111;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << sel);
         seg <= lz_mask[sel] ? SEG_BLANK : seg_dec;
         dp  <= ~dp_mux;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int checks;
   int errors;
   int t;

   seven_seg_scanner #(
      .DIV_WIDTH    (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .digits   (digits),
      .dp_en    (dp_en),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; t counts edges since the last reset release
   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   // Tick until the outputs show slot s at prescaler count c
   task automatic goto(input int s, input int c);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!((((t - 1) & 15) == c) && ((((t - 1) >> 4) & 3) == s)) && n < 80);
      if (n >= 80) begin
         checks++;
         errors++;
         $display("FAIL goto_timeout got %0d expected slot %0d cnt %0d", t, s, c);
      end
   endtask

   task automatic expect_slot(input string tag, input int s, input int c,
                              input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
      goto(s, c);
      check({tag, "_an"},  {12'd0, an},  {12'd0, e_an});
      check({tag, "_seg"}, {9'd0, seg},  {9'd0, e_seg});
      check({tag, "_dp"},  {15'd0, dp},  {15'd0, e_dp});
   endtask

   logic [3:0] an_tab  [4];
   logic [6:0] seg1234 [4];

   initial begin
      checks   = 0;
      errors   = 0;
      t        = 0;
      rst      = 1'b1;
      digits   = 16'h1234;
      dp_en    = 4'b0000;
      blank_lz = 1'b0;
      an_tab[0]  = 4'b1110; an_tab[1]  = 4'b1101; an_tab[2]  = 4'b1011; an_tab[3]  = 4'b0111;
      seg1234[0] = 7'b0011001; seg1234[1] = 7'b0110000;
      seg1234[2] = 7'b0100100; seg1234[3] = 7'b1111001;

      // 1. reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_an",  {12'd0, an}, 16'h000f);
         check("rst_seg", {9'd0, seg}, 16'h007f);
         check("rst_dp",  {15'd0, dp}, 16'h0001);
      end
      rst = 1'b0;
      t   = 0;
      tick();
      check("rel1_an", {12'd0, an}, 16'h000f);
      tick();
      check("rel2_an", {12'd0, an}, 16'h000f);
      tick();
      check("rel3_an",  {12'd0, an}, 16'h000e);
      check("rel3_seg", {9'd0, seg}, 16'h0019);

      // 2. two full scans of 1234
      for (int lap = 0; lap < 2; lap++) begin
         for (int s = 0; s < 4; s++) begin
            expect_slot("scan_blank", s, 1, 4'b1111, 7'b1111111, 1'b1);
            expect_slot("scan", s, 9, an_tab[s], seg1234[s], 1'b1);
         end
      end

      // 3. leading-zero blanking of 0009
      digits   = 16'h0009;
      blank_lz = 1'b1;
      expect_slot("lz9_d0", 0, 5, 4'b1110, 7'b0010000, 1'b1);
      expect_slot("lz9_d1", 1, 5, 4'b1101, 7'b1111111, 1'b1);
      expect_slot("lz9_d2", 2, 5, 4'b1011, 7'b1111111, 1'b1);
      expect_slot("lz9_d3", 3, 5, 4'b0111, 7'b1111111, 1'b1);
      blank_lz = 1'b0;
      expect_slot("nolz_d1", 1, 5, 4'b1101, 7'b1000000, 1'b1);
      expect_slot("nolz_d2", 2, 5, 4'b1011, 7'b1000000, 1'b1);
      expect_slot("nolz_d3", 3, 5, 4'b0111, 7'b1000000, 1'b1);

      // 4. invalid code counts as non-zero; d0 never blanked
      digits   = 16'h00A0;
      blank_lz = 1'b1;
      expect_slot("lza_d0", 0, 7, 4'b1110, 7'b1000000, 1'b1);
      expect_slot("lza_d1", 1, 7, 4'b1101, 7'b0111111, 1'b1);
      expect_slot("lza_d2", 2, 7, 4'b1011, 7'b1111111, 1'b1);
      expect_slot("lza_d3", 3, 7, 4'b0111, 7'b1111111, 1'b1);

      // 5. decimal point on digit 2 only
      dp_en = 4'b0100;
      expect_slot("dp_d0", 0, 4, 4'b1110, 7'b1000000, 1'b1);
      expect_slot("dp_d1", 1, 4, 4'b1101, 7'b0111111, 1'b1);
      expect_slot("dp_g2", 2, 0, 4'b1111, 7'b1111111, 1'b1);
      expect_slot("dp_g2b", 2, 1, 4'b1111, 7'b1111111, 1'b1);
      expect_slot("dp_d2", 2, 3, 4'b1011, 7'b1111111, 1'b0);
      expect_slot("dp_d3", 3, 4, 4'b0111, 7'b1111111, 1'b1);

      // 6. reset pulse in slot 2 while the internal count is 9
      expect_slot("pre_rst", 2, 8, 4'b1011, 7'b1111111, 1'b0);
      rst = 1'b1;
      tick();
      check("midrst_an",  {12'd0, an}, 16'h000f);
      check("midrst_seg", {9'd0, seg}, 16'h007f);
      check("midrst_dp",  {15'd0, dp}, 16'h0001);
      rst = 1'b0;
      t   = 0;
      tick();
      check("post1_an", {12'd0, an}, 16'h000f);
      tick();
      check("post2_an", {12'd0, an}, 16'h000f);
      tick();
      check("post3_an",  {12'd0, an}, 16'h000e);
      check("post3_seg", {9'd0, seg}, 16'h0040);
      check("post3_dp",  {15'd0, dp}, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
